// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing a single-ported data memory between
// two requesters, with address range checking and locked read-modify-write.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [DATA_W-1:0] mem_din,
    output logic [31:0]       mem_addr,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        RR    = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   tag_q, tag_d;
    logic   valid_q, valid_d;
    logic   err_q, err_d;

    logic              gnt_any;
    logic              sel;
    logic              sel_we;
    logic              sel_lock;
    logic [AW-1:0]     sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              oor;

    // State, pointer and pending-response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RR;
            ptr_q   <= 1'b0;
            tag_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Grant selection, next state and response bookkeeping
    always_comb begin
        p0_gnt  = 1'b0;
        p1_gnt  = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;

        // Grants are suppressed while reset is held so the memory sees no write
        if (rst) begin
            case (state_q)
                RR: begin
                    if (p0_req && (!p1_req || !ptr_q)) p0_gnt = 1'b1;
                    else if (p1_req)                   p1_gnt = 1'b1;
                end
                LOCK0:   p0_gnt = p0_req;
                LOCK1:   p1_gnt = p1_req;
                default: ;
            endcase
        end

        gnt_any   = p0_gnt | p1_gnt;
        sel       = p1_gnt;
        sel_we    = sel ? p1_we    : p0_we;
        sel_lock  = sel ? p1_lock  : p0_lock;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        oor       = |sel_addr[AW-1:ADDR_W];

        if (gnt_any) begin
            case (state_q)
                RR: begin
                    ptr_d = ~sel;
                    if (sel_lock) state_d = sel ? LOCK1 : LOCK0;
                end
                LOCK0, LOCK1: begin
                    if (!sel_lock) state_d = RR;
                end
                default: state_d = RR;
            endcase
        end

        valid_d = gnt_any & ~sel_we;
        err_d   = gnt_any & oor;
        tag_d   = sel;
    end

    assign mem_addr = gnt_any ? sel_addr  : '0;
    assign mem_din  = gnt_any ? sel_wdata : '0;
    assign mem_wr   = gnt_any & sel_we & ~oor;

    // Responses steered to the port that owned the previous grant
    assign p0_rvalid = valid_q & ~tag_q;
    assign p1_rvalid = valid_q &  tag_q;
    assign p0_err    = err_q   & ~tag_q;
    assign p1_err    = err_q   &  tag_q;
    assign p0_rdata  = (p0_rvalid && !err_q) ? mem_dout : '0;
    assign p1_rdata  = (p1_rvalid && !err_q) ? mem_dout : '0;

endmodule
